spu_writeback_pipe: RTL

- Writer side of the SPU register table. Collects results from the even and odd execution pipes.
- Each pipe's execution units have a different latency. This block holds every result in a per-pipe staging pipeline until the fixed writeback stage, then drives rt_addr/rt/reg_write into the register table.
- It guarantees in-order, fixed-latency register writes for both pipes and flags writeback hazards.

---
 rtl/spu_writeback_pipe.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spu_writeback_pipe.sv
// SPU writeback staging: per-pipe shift pipelines align results to a fixed register-table write stage.
// Latency DEPTH-stage+1 cycles from insert to write; no backpressure. Optional forwarding: SPU_WB_FORWARD_EN.
module spu_writeback_pipe #(
    parameter int DEPTH  = 7,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid_even,
    input  logic [2:0]        res_stage_even,
    input  logic [ADDR_W-1:0] res_addr_even,
    input  logic [DATA_W-1:0] res_data_even,
    input  logic              res_valid_odd,
    input  logic [2:0]        res_stage_odd,
    input  logic [ADDR_W-1:0] res_addr_odd,
    input  logic [DATA_W-1:0] res_data_odd,
    output logic [ADDR_W-1:0] rt_addr_even,
    output logic [DATA_W-1:0] rt_even,
    output logic              reg_write_even,
    output logic [ADDR_W-1:0] rt_addr_odd,
    output logic [DATA_W-1:0] rt_odd,
    output logic              reg_write_odd,
    output logic              err_stage,
    output logic              err_collide,
    output logic              err_waw
`ifdef SPU_WB_FORWARD_EN
    ,
    input  logic [ADDR_W-1:0] fwd_addr_a,
    input  logic [ADDR_W-1:0] fwd_addr_b,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic [DATA_W-1:0] fwd_data_b
`endif
);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } slot_t;

    // Index 0 is the even pipe, 1 the odd pipe.
    slot_t slot_q [2][1:DEPTH];
    slot_t slot_d [2][1:DEPTH];

    logic              in_vld   [2];
    logic [2:0]        in_stage [2];
    logic [ADDR_W-1:0] in_addr  [2];
    logic [DATA_W-1:0] in_data  [2];

    logic stage_bad;
    logic collide;
    logic waw;

    assign in_vld[0]   = res_valid_even;
    assign in_stage[0] = res_stage_even;
    assign in_addr[0]  = res_addr_even;
    assign in_data[0]  = res_data_even;
    assign in_vld[1]   = res_valid_odd;
    assign in_stage[1] = res_stage_odd;
    assign in_addr[1]  = res_addr_odd;
    assign in_data[1]  = res_data_odd;

    always_comb begin
        stage_bad = 1'b0;
        collide   = 1'b0;
        for (int p = 0; p < 2; p++) begin
            slot_d[p][1] = '0;
            for (int i = 2; i <= DEPTH; i++) begin
                slot_d[p][i] = slot_q[p][i-1];
            end
            if (in_vld[p]) begin
                if (in_stage[p] == 3'd0 || 32'(in_stage[p]) > DEPTH) begin
                    stage_bad = 1'b1;
                end else begin
                    for (int i = 1; i <= DEPTH; i++) begin
                        if (32'(in_stage[p]) == i) begin
                            if (slot_d[p][i].vld) collide = 1'b1;
                            slot_d[p][i] = {1'b1, in_addr[p], in_data[p]};
                        end
                    end
                end
            end
        end
    end

    // WAW is judged on the registered retiring slots so odd's enable has a short path.
    assign waw = slot_q[0][DEPTH].vld && slot_q[1][DEPTH].vld &&
                 (slot_q[0][DEPTH].addr == slot_q[1][DEPTH].addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 1; i <= DEPTH; i++) begin
                    slot_q[p][i] <= '0;
                end
            end
            err_stage   <= 1'b0;
            err_collide <= 1'b0;
            err_waw     <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            err_stage   <= err_stage | stage_bad;
            err_collide <= err_collide | collide;
            err_waw     <= err_waw | waw;
        end
    end

    assign reg_write_even = slot_q[0][DEPTH].vld;
    assign rt_addr_even   = slot_q[0][DEPTH].vld ? slot_q[0][DEPTH].addr : '0;
    assign rt_even        = slot_q[0][DEPTH].vld ? slot_q[0][DEPTH].data : '0;
    assign reg_write_odd  = slot_q[1][DEPTH].vld && !waw;
    assign rt_addr_odd    = slot_q[1][DEPTH].vld ? slot_q[1][DEPTH].addr : '0;
    assign rt_odd         = slot_q[1][DEPTH].vld ? slot_q[1][DEPTH].data : '0;

`ifdef SPU_WB_FORWARD_EN
    // Scan oldest to youngest, odd before even, so the last match is the winner.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0] r;
        r = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            for (int p = 1; p >= 0; p--) begin
                if (slot_q[p][i].vld && slot_q[p][i].addr == a) r = {1'b1, slot_q[p][i].data};
            end
        end
        return r;
    endfunction

    always_comb begin
        {fwd_hit_a, fwd_data_a} = fwd_lookup(fwd_addr_a);
        {fwd_hit_b, fwd_data_b} = fwd_lookup(fwd_addr_b);
    end
`endif

endmodule
